// File: rtl/cache_mesi_array.sv
// cache_mesi_array: MESI coherence state store and transition engine for
// NUM_SETS x NUM_WAYS L2 lines. One command per cycle, response one cycle
// later. Optional Owned state is enabled by defining MESI_OWNED_EN.

package cache_mesi_array_pkg;

    typedef enum logic [2:0] {
        MESI_I = 3'd0,
        MESI_S = 3'd1,
        MESI_E = 3'd2,
        MESI_M = 3'd3,
        MESI_O = 3'd4
    } mesi_t;

    typedef enum logic [2:0] {
        READ_REQ_L1_D      = 3'd0,
        WRITE_REQ_L1_D     = 3'd1,
        READ_REQ_L1_I      = 3'd2,
        SNOOP_INVALID_CMD  = 3'd3,
        SNOOP_READ_REQ     = 3'd4,
        SNOOP_WRITE_REQ    = 3'd5,
        SNOOP_READ_WITH_M  = 3'd6
    } n_struct;

    typedef enum logic [2:0] {
        NULL       = 3'd0,
        READ       = 3'd1,
        WRITE      = 3'd2,
        INVALIDATE = 3'd3,
        RWIM       = 3'd4
    } bus_struct;

    typedef enum logic [2:0] {
        NULLMsg        = 3'd0,
        SENDLINE       = 3'd1,
        GETLINE        = 3'd2,
        INVALIDATELINE = 3'd3,
        EVICTLINE      = 3'd4
    } l2tol1_struct;

endpackage

module cache_mesi_array
    import cache_mesi_array_pkg::*;
#(
    parameter int unsigned NUM_SETS = 16,
    parameter int unsigned NUM_WAYS = 8,
    localparam int unsigned SET_W = $clog2(NUM_SETS),
    localparam int unsigned WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [SET_W-1:0]   req_set,
    input  logic [WAY_W-1:0]   req_way,
    input  n_struct            req_cmd,
    input  logic               req_c_in,
    input  logic               ld_valid,
    input  logic [SET_W-1:0]   ld_set,
    input  logic [WAY_W-1:0]   ld_way,
    input  mesi_t              ld_state,
    output logic               rsp_valid,
    output logic [2:0]         rsp_state_prev,
    output logic [2:0]         rsp_state_next,
    output bus_struct          bus_func_out,
    output l2tol1_struct       l2tol1msg_out,
    output logic               c_out,
    output logic               hitm_out,
    output logic               proto_err
);

    logic [2:0] mem [NUM_SETS][NUM_WAYS];

    logic [WAY_W-1:0] req_way_eff;
    logic [WAY_W-1:0] ld_way_eff;
    logic             accept;

    mesi_t        cur;
    mesi_t        nxt;
    bus_struct    bus_nxt;
    l2tol1_struct msg_nxt;
    logic         c_nxt;
    logic         hitm_nxt;
    logic         err_nxt;

    // Map raw stored/loaded encodings onto legal states; anything unknown is I.
    function automatic mesi_t sanitize(input logic [2:0] v);
        case (v)
            3'd0:    return MESI_I;
            3'd1:    return MESI_S;
            3'd2:    return MESI_E;
            3'd3:    return MESI_M;
`ifdef MESI_OWNED_EN
            3'd4:    return MESI_O;
`endif
            default: return MESI_I;
        endcase
    endfunction

    // With a single way the way index carries no information.
    assign req_way_eff = (NUM_WAYS > 1) ? req_way : '0;
    assign ld_way_eff  = (NUM_WAYS > 1) ? ld_way  : '0;

    assign req_ready = !rstb && !ld_valid;
    assign accept    = req_valid && req_ready;
    assign cur       = sanitize(mem[req_set][req_way_eff]);

    // MESI next-state, bus operation, L1 message and snoop flags for the addressed line.
    always_comb begin
        nxt      = cur;
        bus_nxt  = NULL;
        msg_nxt  = NULLMsg;
        c_nxt    = 1'b0;
        hitm_nxt = 1'b0;
        err_nxt  = 1'b0;
        case (cur)
            MESI_I: begin
                case (req_cmd)
                    READ_REQ_L1_D, READ_REQ_L1_I: begin
                        nxt     = req_c_in ? MESI_S : MESI_E;
                        bus_nxt = READ;
                        msg_nxt = SENDLINE;
                    end
                    WRITE_REQ_L1_D: begin
                        nxt     = MESI_M;
                        bus_nxt = RWIM;
                        msg_nxt = SENDLINE;
                    end
                    default: ;
                endcase
            end
            MESI_S: begin
                case (req_cmd)
                    READ_REQ_L1_D, READ_REQ_L1_I: msg_nxt = SENDLINE;
                    WRITE_REQ_L1_D: begin
                        nxt     = MESI_M;
                        bus_nxt = INVALIDATE;
                        msg_nxt = GETLINE;
                    end
                    SNOOP_READ_REQ: c_nxt = 1'b1;
                    SNOOP_READ_WITH_M, SNOOP_WRITE_REQ, SNOOP_INVALID_CMD: begin
                        nxt     = MESI_I;
                        msg_nxt = INVALIDATELINE;
                        c_nxt   = 1'b1;
                    end
                    default: ;
                endcase
            end
            MESI_E: begin
                case (req_cmd)
                    READ_REQ_L1_D, READ_REQ_L1_I: msg_nxt = SENDLINE;
                    WRITE_REQ_L1_D: begin
                        nxt     = MESI_M;
                        msg_nxt = GETLINE;
                    end
                    SNOOP_READ_REQ: begin
                        nxt   = MESI_S;
                        c_nxt = 1'b1;
                    end
                    SNOOP_READ_WITH_M, SNOOP_WRITE_REQ: begin
                        nxt     = MESI_I;
                        msg_nxt = INVALIDATELINE;
                        c_nxt   = 1'b1;
                    end
                    SNOOP_INVALID_CMD: err_nxt = 1'b1;
                    default: ;
                endcase
            end
            MESI_M: begin
                case (req_cmd)
                    READ_REQ_L1_D, READ_REQ_L1_I, WRITE_REQ_L1_D: msg_nxt = SENDLINE;
                    SNOOP_READ_REQ: begin
`ifdef MESI_OWNED_EN
                        nxt      = MESI_O;
`else
                        nxt      = MESI_S;
                        bus_nxt  = WRITE;
`endif
                        c_nxt    = 1'b1;
                        hitm_nxt = 1'b1;
                    end
                    SNOOP_READ_WITH_M, SNOOP_WRITE_REQ: begin
                        nxt      = MESI_I;
                        bus_nxt  = WRITE;
                        msg_nxt  = EVICTLINE;
                        c_nxt    = 1'b1;
                        hitm_nxt = 1'b1;
                    end
                    SNOOP_INVALID_CMD: err_nxt = 1'b1;
                    default: ;
                endcase
            end
`ifdef MESI_OWNED_EN
            MESI_O: begin
                case (req_cmd)
                    READ_REQ_L1_D, READ_REQ_L1_I: msg_nxt = SENDLINE;
                    WRITE_REQ_L1_D: begin
                        nxt     = MESI_M;
                        bus_nxt = INVALIDATE;
                        msg_nxt = GETLINE;
                    end
                    SNOOP_READ_REQ: begin
                        c_nxt    = 1'b1;
                        hitm_nxt = 1'b1;
                    end
                    SNOOP_READ_WITH_M, SNOOP_WRITE_REQ: begin
                        nxt      = MESI_I;
                        bus_nxt  = WRITE;
                        msg_nxt  = EVICTLINE;
                        c_nxt    = 1'b1;
                        hitm_nxt = 1'b1;
                    end
                    SNOOP_INVALID_CMD: begin
                        nxt     = MESI_I;
                        bus_nxt = WRITE;
                        msg_nxt = INVALIDATELINE;
                    end
                    default: ;
                endcase
            end
`endif
            default: ;
        endcase
    end

    // State array update (load has priority over a command) and registered response.
    always_ff @(posedge clk) begin
        if (rstb) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                    mem[s][w] <= MESI_I;
                end
            end
            rsp_valid      <= 1'b0;
            rsp_state_prev <= '0;
            rsp_state_next <= '0;
            bus_func_out   <= NULL;
            l2tol1msg_out  <= NULLMsg;
            c_out          <= 1'b0;
            hitm_out       <= 1'b0;
            proto_err      <= 1'b0;
        end else begin
            if (ld_valid) begin
                mem[ld_set][ld_way_eff] <= sanitize(ld_state);
            end else if (accept) begin
                mem[req_set][req_way_eff] <= nxt;
            end
            rsp_valid <= accept;
            if (accept) begin
                rsp_state_prev <= cur;
                rsp_state_next <= nxt;
                bus_func_out   <= bus_nxt;
                l2tol1msg_out  <= msg_nxt;
                c_out          <= c_nxt;
                hitm_out       <= hitm_nxt;
                proto_err      <= err_nxt;
            end else begin
                rsp_state_prev <= '0;
                rsp_state_next <= '0;
                bus_func_out   <= NULL;
                l2tol1msg_out  <= NULLMsg;
                c_out          <= 1'b0;
                hitm_out       <= 1'b0;
                proto_err      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cache_mesi_array.sv
// Scoreboard bench for cache_mesi_array: directed commands push hand-computed
// responses tagged with the cycle they are due; a negedge monitor compares
// them, and checks idle outputs on every other cycle.
module tb_cache_mesi_array;
    import cache_mesi_array_pkg::*;

    logic         clk = 1'b0;
    logic         rstb;
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_set;
    logic [2:0]   req_way;
    n_struct      req_cmd;
    logic         req_c_in;
    logic         ld_valid;
    logic [3:0]   ld_set;
    logic [2:0]   ld_way;
    mesi_t        ld_state;
    logic         rsp_valid;
    logic [2:0]   rsp_state_prev;
    logic [2:0]   rsp_state_next;
    bus_struct    bus_func_out;
    l2tol1_struct l2tol1msg_out;
    logic         c_out;
    logic         hitm_out;
    logic         proto_err;

    cache_mesi_array #(.NUM_SETS(16), .NUM_WAYS(8)) dut (
        .clk(clk), .rstb(rstb),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_set(req_set), .req_way(req_way), .req_cmd(req_cmd), .req_c_in(req_c_in),
        .ld_valid(ld_valid), .ld_set(ld_set), .ld_way(ld_way), .ld_state(ld_state),
        .rsp_valid(rsp_valid), .rsp_state_prev(rsp_state_prev), .rsp_state_next(rsp_state_next),
        .bus_func_out(bus_func_out), .l2tol1msg_out(l2tol1msg_out),
        .c_out(c_out), .hitm_out(hitm_out), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           id;
        int           due;
        logic [2:0]   p;
        logic [2:0]   n;
        bus_struct    b;
        l2tol1_struct m;
        logic         c;
        logic         h;
        logic         pe;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;
    int   next_id = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare due responses, otherwise require idle outputs.
    always @(negedge clk) begin
        if (chk_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                tests++;
                if (!(rsp_valid === 1'b1 && rsp_state_prev === e.p && rsp_state_next === e.n &&
                      bus_func_out === e.b && l2tol1msg_out === e.m && c_out === e.c &&
                      hitm_out === e.h && proto_err === e.pe)) begin
                    fails++;
                    $display("FAIL rsp%0d: got v=%0b prev=%0d next=%0d bus=%0d msg=%0d c=%0b h=%0b err=%0b, want v=1 prev=%0d next=%0d bus=%0d msg=%0d c=%0b h=%0b err=%0b",
                             e.id, rsp_valid, rsp_state_prev, rsp_state_next, bus_func_out, l2tol1msg_out,
                             c_out, hitm_out, proto_err, e.p, e.n, e.b, e.m, e.c, e.h, e.pe);
                end
            end else begin
                tests++;
                if (!(rsp_valid === 1'b0 && bus_func_out === NULL && l2tol1msg_out === NULLMsg &&
                      c_out === 1'b0 && hitm_out === 1'b0 && proto_err === 1'b0)) begin
                    fails++;
                    $display("FAIL idle@%0d: got v=%0b bus=%0d msg=%0d c=%0b h=%0b err=%0b, want all 0",
                             cyc, rsp_valid, bus_func_out, l2tol1msg_out, c_out, hitm_out, proto_err);
                end
            end
        end
    end

    // Present one command for one cycle; called at posedge+1.
    task automatic issue(input logic [3:0] s, input logic [2:0] w, input n_struct c, input logic cin,
                         input mesi_t p, input mesi_t n, input bus_struct b, input l2tol1_struct m,
                         input logic co, input logic hm, input logic pe);
        exp_t e;
        req_valid = 1'b1;
        req_set   = s;
        req_way   = w;
        req_cmd   = c;
        req_c_in  = cin;
        e.id = next_id; e.due = cyc + 1;
        e.p = p; e.n = n; e.b = b; e.m = m; e.c = co; e.h = hm; e.pe = pe;
        next_id++;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic load(input logic [3:0] s, input logic [2:0] w, input mesi_t st);
        ld_valid = 1'b1;
        ld_set   = s;
        ld_way   = w;
        ld_state = st;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
    endtask

    task automatic check_ready(input logic want, input int tag);
        tests++;
        if (req_ready !== want) begin
            fails++;
            $display("FAIL ready%0d: got %0b, want %0b", tag, req_ready, want);
        end
    endtask

    n_struct bad_cmd;
    mesi_t   bad_state;
    mesi_t   o_state;

    initial begin
        bad_cmd   = n_struct'(3'd7);
        bad_state = mesi_t'(3'd7);
        o_state   = mesi_t'(3'd4);
        rstb = 1'b1;
        req_valid = 1'b0; req_set = '0; req_way = '0; req_cmd = READ_REQ_L1_D; req_c_in = 1'b0;
        ld_valid = 1'b0; ld_set = '0; ld_way = '0; ld_state = MESI_I;
        repeat (2) @(posedge clk);
        #1;
        check_ready(1'b0, 0);
        rstb = 1'b0;
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        // Read miss then hit, illegal snoop-invalidate on E, unknown command
        issue(3, 5, READ_REQ_L1_D, 0, MESI_I, MESI_E, READ, SENDLINE, 0, 0, 0);
        issue(3, 5, READ_REQ_L1_I, 0, MESI_E, MESI_E, NULL, SENDLINE, 0, 0, 0);
        issue(3, 5, SNOOP_INVALID_CMD, 0, MESI_E, MESI_E, NULL, NULLMsg, 0, 0, 1);
        issue(3, 5, bad_cmd, 0, MESI_E, MESI_E, NULL, NULLMsg, 0, 0, 0);

        // Write miss, then snoop read on M
        issue(1, 0, WRITE_REQ_L1_D, 0, MESI_I, MESI_M, RWIM, SENDLINE, 0, 0, 0);
`ifdef MESI_OWNED_EN
        issue(1, 0, SNOOP_READ_REQ, 0, MESI_M, MESI_O, NULL, NULLMsg, 1, 1, 0);
`else
        issue(1, 0, SNOOP_READ_REQ, 0, MESI_M, MESI_S, WRITE, NULLMsg, 1, 1, 0);
`endif

        // Shared read miss, snoop invalidate from S, snoop on I
        issue(2, 1, READ_REQ_L1_D, 1, MESI_I, MESI_S, READ, SENDLINE, 0, 0, 0);
        issue(2, 1, SNOOP_INVALID_CMD, 0, MESI_S, MESI_I, NULL, INVALIDATELINE, 1, 0, 0);
        issue(2, 1, SNOOP_READ_REQ, 0, MESI_I, MESI_I, NULL, NULLMsg, 0, 0, 0);

        // Load and command together: load wins, command accepted next cycle
        ld_valid = 1'b1; ld_set = 4; ld_way = 2; ld_state = MESI_S;
        req_valid = 1'b1; req_set = 4; req_way = 2; req_cmd = READ_REQ_L1_D; req_c_in = 1'b0;
        #1;
        check_ready(1'b0, 1);
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        #1;
        check_ready(1'b1, 2);
        issue(4, 2, READ_REQ_L1_D, 0, MESI_S, MESI_S, NULL, SENDLINE, 0, 0, 0);

        // Unknown and Owned encodings on the load path
        load(5, 3, bad_state);
        issue(5, 3, READ_REQ_L1_D, 1, MESI_I, MESI_S, READ, SENDLINE, 0, 0, 0);
        load(6, 0, o_state);
        load(8, 0, o_state);
`ifdef MESI_OWNED_EN
        issue(6, 0, READ_REQ_L1_D, 0, MESI_O, MESI_O, NULL, SENDLINE, 0, 0, 0);
        issue(8, 0, SNOOP_INVALID_CMD, 0, MESI_O, MESI_I, WRITE, INVALIDATELINE, 0, 0, 0);
`else
        issue(6, 0, READ_REQ_L1_D, 0, MESI_I, MESI_E, READ, SENDLINE, 0, 0, 0);
        issue(8, 0, SNOOP_INVALID_CMD, 0, MESI_I, MESI_I, NULL, NULLMsg, 0, 0, 0);
`endif

        // Eight back-to-back commands to one line
        issue(7, 7, READ_REQ_L1_D, 0, MESI_I, MESI_E, READ, SENDLINE, 0, 0, 0);
        issue(7, 7, WRITE_REQ_L1_D, 0, MESI_E, MESI_M, NULL, GETLINE, 0, 0, 0);
`ifdef MESI_OWNED_EN
        issue(7, 7, SNOOP_READ_REQ, 0, MESI_M, MESI_O, NULL, NULLMsg, 1, 1, 0);
        issue(7, 7, WRITE_REQ_L1_D, 0, MESI_O, MESI_M, INVALIDATE, GETLINE, 0, 0, 0);
`else
        issue(7, 7, SNOOP_READ_REQ, 0, MESI_M, MESI_S, WRITE, NULLMsg, 1, 1, 0);
        issue(7, 7, WRITE_REQ_L1_D, 0, MESI_S, MESI_M, INVALIDATE, GETLINE, 0, 0, 0);
`endif
        issue(7, 7, SNOOP_WRITE_REQ, 0, MESI_M, MESI_I, WRITE, EVICTLINE, 1, 1, 0);
        issue(7, 7, READ_REQ_L1_D, 0, MESI_I, MESI_E, READ, SENDLINE, 0, 0, 0);
        issue(7, 7, SNOOP_READ_REQ, 0, MESI_E, MESI_S, NULL, NULLMsg, 1, 0, 0);
        issue(7, 7, SNOOP_READ_WITH_M, 0, MESI_S, MESI_I, NULL, INVALIDATELINE, 1, 0, 0);

        // Corner lines in M, reset mid-stream, then both lines read as I
        load(0, 0, MESI_M);
        load(15, 7, MESI_M);
        issue(0, 0, READ_REQ_L1_D, 0, MESI_M, MESI_M, NULL, SENDLINE, 0, 0, 0);
        rstb = 1'b1;
        req_valid = 1'b1; req_set = 15; req_way = 7; req_cmd = READ_REQ_L1_D;
        #1;
        check_ready(1'b0, 3);
        @(posedge clk);
        #1;
        rstb = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        issue(0, 0, READ_REQ_L1_D, 0, MESI_I, MESI_E, READ, SENDLINE, 0, 0, 0);
        issue(15, 7, READ_REQ_L1_D, 0, MESI_I, MESI_E, READ, SENDLINE, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending responses, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
